// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and constants for the forwarding / hazard control slice.
package fwd_hazard_unit_pkg;

    localparam int unsigned REG_ADDR_LEN      = 5;
    localparam int unsigned SEL_LEN           = 2;
    localparam int unsigned REG_FILE_ADDR_LEN = REG_ADDR_LEN;
    localparam int unsigned FORW_SEL_LEN      = SEL_LEN;

    // Operand source chosen by the EXE-stage muxes.
    typedef enum logic [FORW_SEL_LEN-1:0] {
        FORW_SEL_REG = 2'd0,
        FORW_SEL_MEM = 2'd1,
        FORW_SEL_WB  = 2'd2
    } fwd_sel_e;

    // Shadow of one downstream stage; wr already folds in valid, wb_en and dest != 0.
    typedef struct packed {
        logic                    wr;
        logic [REG_ADDR_LEN-1:0] dest;
    } fwd_slot_t;

    // Register 0 is hard-wired, so an instruction targeting it never produces a value.
    function automatic logic is_writer(input logic wb_en, input logic [REG_ADDR_LEN-1:0] dest);
        return wb_en & (dest != '0);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage decode fields in, operand selects and stall out.
interface fwd_hazard_unit_if;
    import fwd_hazard_unit_pkg::*;

    logic [REG_ADDR_LEN-1:0] id_src1;
    logic [REG_ADDR_LEN-1:0] id_src2;
    logic [REG_ADDR_LEN-1:0] id_st_src;
    logic                    id_src2_used;
    logic                    id_is_store;
    logic [REG_ADDR_LEN-1:0] id_dest;
    logic                    id_wb_en;
    logic                    id_mem_read;
    logic                    br_taken;
    logic                    freeze;
    logic                    hazard_stall;
    logic [SEL_LEN-1:0]      val1_sel;
    logic [SEL_LEN-1:0]      val2_sel;
    logic [SEL_LEN-1:0]      ST_val_sel;

    // Pipeline side: drives decode/control, consumes selects and stall.
    modport master (
        output id_src1, id_src2, id_st_src, id_src2_used, id_is_store,
               id_dest, id_wb_en, id_mem_read, br_taken, freeze,
        input  hazard_stall, val1_sel, val2_sel, ST_val_sel
    );

    // Hazard unit side.
    modport slave (
        input  id_src1, id_src2, id_st_src, id_src2_used, id_is_store,
               id_dest, id_wb_en, id_mem_read, br_taken, freeze,
        output hazard_stall, val1_sel, val2_sel, ST_val_sel
    );
endinterface

// File: rtl/fwd_src_match.sv
// Priority compare of one source register against the EXE (near) and MEM (far) slots.
module fwd_src_match
    import fwd_hazard_unit_pkg::*;
(
    input  logic [REG_ADDR_LEN-1:0] src_i,
    input  logic                    src_used_i,
    input  fwd_slot_t               near_i,
    input  fwd_slot_t               far_i,
    output fwd_sel_e                sel_c_o
);

    // Nearer producer wins; unused sources never match.
    always_comb begin
        sel_c_o = FORW_SEL_REG;
        if (src_used_i) begin
            if (near_i.wr && (near_i.dest == src_i)) begin
                sel_c_o = FORW_SEL_MEM;
            end else if (far_i.wr && (far_i.dest == src_i)) begin
                sel_c_o = FORW_SEL_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall control sitting beside the ID/EXE register.
// Build option FWD_HAZARD_FORWARDING_EN: when defined, operands are forwarded and
// only load-use stalls; when undefined, selects read 0 and any in-flight producer
// in EXE or MEM stalls the dependent instruction.
// The WB stage is not shadowed: the register file is write-before-read, so a WB
// producer never affects a select or a stall.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    fwd_hazard_unit_if.slave hz_if
);

    fwd_slot_t exe_q;
    fwd_slot_t exe_d;
    fwd_slot_t mem_q;
    fwd_sel_e  sel1_c;
    fwd_sel_e  sel2_c;
    fwd_sel_e  sel_st_c;
    logic      stall_c;
    logic      bubble_c;

    fwd_src_match u_match_src1 (
        .src_i      (hz_if.id_src1),
        .src_used_i (1'b1),
        .near_i     (exe_q),
        .far_i      (mem_q),
        .sel_c_o    (sel1_c)
    );

    fwd_src_match u_match_src2 (
        .src_i      (hz_if.id_src2),
        .src_used_i (hz_if.id_src2_used),
        .near_i     (exe_q),
        .far_i      (mem_q),
        .sel_c_o    (sel2_c)
    );

    fwd_src_match u_match_st (
        .src_i      (hz_if.id_st_src),
        .src_used_i (hz_if.id_is_store),
        .near_i     (exe_q),
        .far_i      (mem_q),
        .sel_c_o    (sel_st_c)
    );

`ifdef FWD_HAZARD_FORWARDING_EN
    logic               exe_ld_q;
    logic [SEL_LEN-1:0] val1_sel_q;
    logic [SEL_LEN-1:0] val2_sel_q;
    logic [SEL_LEN-1:0] st_val_sel_q;

    // Load-use only: an EXE match means the producer sits in EXE right now.
    always_comb begin
        stall_c = exe_ld_q && ((sel1_c   == FORW_SEL_MEM) ||
                               (sel2_c   == FORW_SEL_MEM) ||
                               (sel_st_c == FORW_SEL_MEM));
        if (!rst || hz_if.br_taken) begin
            stall_c = 1'b0;
        end
    end

    // Select registers and load flag advance with the ID/EXE register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            exe_ld_q     <= 1'b0;
            val1_sel_q   <= '0;
            val2_sel_q   <= '0;
            st_val_sel_q <= '0;
        end else if (!hz_if.freeze) begin
            exe_ld_q     <= !bubble_c && hz_if.id_mem_read;
            val1_sel_q   <= bubble_c ? SEL_LEN'(FORW_SEL_REG) : SEL_LEN'(sel1_c);
            val2_sel_q   <= bubble_c ? SEL_LEN'(FORW_SEL_REG) : SEL_LEN'(sel2_c);
            st_val_sel_q <= bubble_c ? SEL_LEN'(FORW_SEL_REG) : SEL_LEN'(sel_st_c);
        end
    end

    assign hz_if.val1_sel   = val1_sel_q;
    assign hz_if.val2_sel   = val2_sel_q;
    assign hz_if.ST_val_sel = st_val_sel_q;
`else
    // Without forwarding any pending producer blocks the consumer.
    always_comb begin
        stall_c = (sel1_c   != FORW_SEL_REG) ||
                  (sel2_c   != FORW_SEL_REG) ||
                  (sel_st_c != FORW_SEL_REG);
        if (!rst || hz_if.br_taken) begin
            stall_c = 1'b0;
        end
    end

    assign hz_if.val1_sel   = '0;
    assign hz_if.val2_sel   = '0;
    assign hz_if.ST_val_sel = '0;
`endif

    assign bubble_c           = hz_if.br_taken || stall_c;
    assign hz_if.hazard_stall = stall_c;

    // Next EXE slot: ID instruction or a bubble.
    always_comb begin
        exe_d = '0;
        if (!bubble_c) begin
            exe_d.wr   = is_writer(hz_if.id_wb_en, hz_if.id_dest);
            exe_d.dest = hz_if.id_dest;
        end
    end

    // Destination shadow pipeline, held under freeze.
    always_ff @(posedge clk) begin
        if (!rst) begin
            exe_q <= '0;
            mem_q <= '0;
        end else if (!hz_if.freeze) begin
            exe_q <= exe_d;
            mem_q <= exe_q;
        end
    end

endmodule
